// File: rtl/dcache_stbuf_if.sv
// Store buffer bus: D$ store enqueue, write-through drain, load forward.
// The slave modport is the buffer's view; master is the D$/memory side.
interface dcache_stbuf_if #(
  parameter int DW = 32
);
  localparam int NB = DW / 8;

  logic          enq_valid_i;
  logic [31:0]   enq_addr_i;
  logic [DW-1:0] enq_wdata_i;
  logic [NB-1:0] enq_wstrb_i;
  logic          enq_ready_o;

  logic          mem_valid_o;
  logic [31:0]   mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [NB-1:0] mem_wstrb_o;
  logic          mem_ready_i;

  logic          fwd_req_i;
  logic [31:0]   fwd_addr_i;
  logic          fwd_hit_o;
  logic          fwd_partial_o;
  logic [DW-1:0] fwd_data_o;
  logic [NB-1:0] fwd_strb_o;

  modport slave (
    input  enq_valid_i, enq_addr_i, enq_wdata_i, enq_wstrb_i,
    output enq_ready_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ready_i,
    input  fwd_req_i, fwd_addr_i,
    output fwd_hit_o, fwd_partial_o, fwd_data_o, fwd_strb_o
  );

  modport master (
    output enq_valid_i, enq_addr_i, enq_wdata_i, enq_wstrb_i,
    input  enq_ready_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_ready_i,
    output fwd_req_i, fwd_addr_i,
    input  fwd_hit_o, fwd_partial_o, fwd_data_o, fwd_strb_o
  );
endinterface

// File: rtl/dcache_stbuf.sv
// Coalescing store buffer between D$ stores and write-through memory,
// with byte-accurate load forwarding and a flush/fence drain handshake.
module dcache_stbuf #(
  parameter int DEPTH    = 4,
  parameter int DW       = 32,
  parameter bit COALESCE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dcache_stbuf_if.slave              bus,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PW:0]      r_head, r_tail;
  logic [DEPTH-1:0] r_valid;
  logic [31:0]      r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [NB-1:0]    r_strb [DEPTH];
  logic [CW-1:0]    r_count;

  logic [PW-1:0] w_hidx, w_tidx, w_yidx, w_fidx;
  logic          w_full, w_empty;
  logic          w_coal, w_ready, w_fire;
  logic          w_push, w_cacc, w_pop;
  logic          w_done;
  logic [DW-1:0] w_mdata;
  logic [DW-1:0] w_fdata;
  logic [NB-1:0] w_fstrb;
  logic          w_unused;

  assign w_hidx  = r_head[PW-1:0];
  assign w_tidx  = r_tail[PW-1:0];
  assign w_yidx  = w_tidx - PW'(1);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // youngest entry is never the head when two or more are queued
  assign w_coal = COALESCE && bus.enq_valid_i
               && (r_count >= CW'(2)) && r_valid[w_yidx]
               && (r_addr[w_yidx][31:OW] == bus.enq_addr_i[31:OW]);

  assign w_ready = (r_state == S_RUN) && (!w_full || w_coal);
  assign w_fire  = bus.enq_valid_i && w_ready;
  assign w_push  = w_fire && !w_coal;
  assign w_cacc  = w_fire && w_coal;
  assign w_pop   = !w_empty && bus.mem_ready_i;

  assign bus.enq_ready_o = w_ready;
  assign bus.mem_valid_o = !w_empty;
  assign bus.mem_addr_o  = r_addr[w_hidx];
  assign bus.mem_wdata_o = r_data[w_hidx];
  assign bus.mem_wstrb_o = r_strb[w_hidx];
  assign count_o         = r_count;
  assign flush_done_o    = w_done;

  assign w_unused = ^bus.fwd_addr_i[OW-1:0];

  always_comb begin
    w_mdata = r_data[w_yidx];
    for (int b = 0; b < NB; b++) begin
      if (bus.enq_wstrb_i[b]) w_mdata[8*b +: 8] = bus.enq_wdata_i[8*b +: 8];
    end
  end

  // oldest to youngest, so later matches overwrite earlier bytes
  always_comb begin
    w_fdata = '0;
    w_fstrb = '0;
    w_fidx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fidx = w_hidx + PW'(i);
      if (r_valid[w_fidx]
          && (r_addr[w_fidx][31:OW] == bus.fwd_addr_i[31:OW])) begin
        for (int b = 0; b < NB; b++) begin
          if (r_strb[w_fidx][b]) w_fdata[8*b +: 8] = r_data[w_fidx][8*b +: 8];
        end
        w_fstrb = w_fstrb | r_strb[w_fidx];
      end
    end
  end

  assign bus.fwd_hit_o     = bus.fwd_req_i && (&w_fstrb);
  assign bus.fwd_partial_o = bus.fwd_req_i && (|w_fstrb) && !(&w_fstrb);
  assign bus.fwd_data_o    = bus.fwd_req_i ? w_fdata : '0;
  assign bus.fwd_strb_o    = bus.fwd_req_i ? w_fstrb : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (flush_i) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_empty) begin
          w_state_nxt = S_RUN;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_strb[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_valid[w_tidx] <= 1'b1;
        r_addr[w_tidx]  <= bus.enq_addr_i;
        r_data[w_tidx]  <= bus.enq_wdata_i;
        r_strb[w_tidx]  <= bus.enq_wstrb_i;
        r_tail          <= r_tail + (PW+1)'(1);
      end
      if (w_cacc) begin
        r_data[w_yidx] <= w_mdata;
        r_strb[w_yidx] <= r_strb[w_yidx] | bus.enq_wstrb_i;
      end
      if (w_pop) begin
        r_valid[w_hidx] <= 1'b0;
        r_head          <= r_head + (PW+1)'(1);
      end
      if (w_push && !w_pop) r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end
endmodule
